// File: rtl/generic_pool_row_task_sched.sv
// Row-task sequencer for one generic-pool job: walks channel (outer) and output row (inner),
// issues one ifmap row-window task per output row under a credit limit, and pulses done at the end.
`timescale 1ns/1ps
module generic_pool_row_task_sched #(
  parameter int MAX_OUTSTANDING = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [2:0]  cfg_pool_vertical_stride,
  input  logic [7:0]  cfg_pool_window_h,
  input  logic [15:0] cfg_ext_ifmap_h,
  input  logic [15:0] cfg_ofmap_h,
  input  logic [15:0] cfg_fmap_chn_n,
  output logic        busy,
  output logic        done,
  output logic        task_valid,
  input  logic        task_ready,
  output logic [15:0] task_chn,
  output logic [15:0] task_ofmap_row,
  output logic [15:0] task_ifmap_row_start,
  output logic [7:0]  task_ifmap_row_n,
  output logic        task_last,
  input  logic        cpl_valid,
  output logic        cpl_err
);

  localparam logic [3:0] MAX_OUT = 4'(MAX_OUTSTANDING);

  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN} state_t;

  state_t      state_reg;
  logic [2:0]  stride_reg;
  logic [7:0]  win_reg;
  logic [15:0] ext_reg;
  logic [15:0] ofh_reg;
  logic [15:0] chn_n_reg;
  logic [3:0]  out_reg;

  logic        hs;
  logic        cpl_zero;
  logic [3:0]  out_next;
  logic        row_wrap;
  logic [15:0] chn_next;
  logic [15:0] row_next;
  logic [15:0] rs_next;
  logic        last_next;

  // Window rows clipped against the bottom of the extended ifmap (17-bit compare).
  function automatic logic [7:0] calc_row_n(input logic [15:0] rs, input logic [7:0] win,
                                            input logic [15:0] ext);
    logic [16:0] sum;
    sum = {1'b0, rs} + {9'd0, win};
    if (sum > {1'b0, ext})
      return 8'(ext - rs);
    else
      return win;
  endfunction

  always_comb begin
    hs       = (state_reg == ISSUE) && task_valid && task_ready;
    cpl_zero = cpl_valid && (out_reg == 4'd0);
    out_next = out_reg;
    if (hs && cpl_valid)
      out_next = out_reg;
    else if (hs)
      out_next = out_reg + 4'd1;
    else if (cpl_valid && !cpl_zero)
      out_next = out_reg - 4'd1;

    row_wrap  = (task_ofmap_row == ofh_reg);
    chn_next  = row_wrap ? task_chn + 16'd1 : task_chn;
    row_next  = row_wrap ? 16'd0 : task_ofmap_row + 16'd1;
    rs_next   = row_wrap ? 16'd0 : task_ifmap_row_start + {13'd0, stride_reg} + 16'd1;
    last_next = (chn_next == chn_n_reg) && (row_next == ofh_reg);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg            <= IDLE;
      stride_reg           <= '0;
      win_reg              <= '0;
      ext_reg              <= '0;
      ofh_reg              <= '0;
      chn_n_reg            <= '0;
      out_reg              <= '0;
      busy                 <= 1'b0;
      done                 <= 1'b0;
      task_valid           <= 1'b0;
      task_chn             <= '0;
      task_ofmap_row       <= '0;
      task_ifmap_row_start <= '0;
      task_ifmap_row_n     <= '0;
      task_last            <= 1'b0;
      cpl_err              <= 1'b0;
    end else begin
      done    <= 1'b0;
      out_reg <= out_next;
      if (cpl_zero)
        cpl_err <= 1'b1;
      case (state_reg)
        IDLE: begin
          if (start) begin
            state_reg            <= ISSUE;
            stride_reg           <= cfg_pool_vertical_stride;
            win_reg              <= cfg_pool_window_h;
            ext_reg              <= cfg_ext_ifmap_h;
            ofh_reg              <= cfg_ofmap_h;
            chn_n_reg            <= cfg_fmap_chn_n;
            out_reg              <= '0;
            busy                 <= 1'b1;
            cpl_err              <= 1'b0;
            // First task is presented straight from the incoming config.
            task_valid           <= 1'b1;
            task_chn             <= '0;
            task_ofmap_row       <= '0;
            task_ifmap_row_start <= '0;
            task_ifmap_row_n     <= calc_row_n(16'd0, cfg_pool_window_h, cfg_ext_ifmap_h);
            task_last            <= (cfg_fmap_chn_n == 16'd0) && (cfg_ofmap_h == 16'd0);
          end
        end
        ISSUE: begin
          if (hs && task_last) begin
            state_reg  <= DRAIN;
            task_valid <= 1'b0;
          end else begin
            task_valid <= (out_next < MAX_OUT);
            if (hs) begin
              task_chn             <= chn_next;
              task_ofmap_row       <= row_next;
              task_ifmap_row_start <= rs_next;
              task_ifmap_row_n     <= calc_row_n(rs_next, win_reg, ext_reg);
              task_last            <= last_next;
            end
          end
        end
        DRAIN: begin
          if (out_next == 4'd0) begin
            state_reg <= IDLE;
            busy      <= 1'b0;
            done      <= 1'b1;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_generic_pool_row_task_sched.sv
// Self-checking bench: table-driven job vectors, hand-written credit/reset/error sequences,
// and randomized jobs checked against a task-list model built from the row/window rules.
`timescale 1ns/1ps
module tb_generic_pool_row_task_sched;

  localparam int MAX = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [2:0]  cfg_pool_vertical_stride = '0;
  logic [7:0]  cfg_pool_window_h = '0;
  logic [15:0] cfg_ext_ifmap_h = '0;
  logic [15:0] cfg_ofmap_h = '0;
  logic [15:0] cfg_fmap_chn_n = '0;
  logic        busy, done, task_valid, task_last, cpl_err;
  logic        task_ready = 1'b0;
  logic        cpl_valid = 1'b0;
  logic [15:0] task_chn, task_ofmap_row, task_ifmap_row_start;
  logic [7:0]  task_ifmap_row_n;

  int checks = 0;
  int errors = 0;
  int hs_cnt = 0;

  typedef struct {int chn; int row; int rs; int rn; int last; int cyc;} tsk_t;
  typedef struct {int cn; int oh; int st; int wh; int eh; int idx;
                  int e_chn; int e_row; int e_rs; int e_rn; int e_last;} vec_t;

  tsk_t got[$];
  vec_t vec[8];

  always #5 clk = ~clk;

  generic_pool_row_task_sched #(.MAX_OUTSTANDING(MAX)) dut (
    .clk(clk), .rst_n(rst_n), .start(start),
    .cfg_pool_vertical_stride(cfg_pool_vertical_stride),
    .cfg_pool_window_h(cfg_pool_window_h),
    .cfg_ext_ifmap_h(cfg_ext_ifmap_h),
    .cfg_ofmap_h(cfg_ofmap_h),
    .cfg_fmap_chn_n(cfg_fmap_chn_n),
    .busy(busy), .done(done),
    .task_valid(task_valid), .task_ready(task_ready),
    .task_chn(task_chn), .task_ofmap_row(task_ofmap_row),
    .task_ifmap_row_start(task_ifmap_row_start),
    .task_ifmap_row_n(task_ifmap_row_n),
    .task_last(task_last),
    .cpl_valid(cpl_valid), .cpl_err(cpl_err)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s act=%0d exp=%0d t=%0t", nm, act, exp, $time);
    end
  endtask

  // One clock: drive ready/cpl for the next edge, count a handshake, return at next negedge.
  task automatic step(input logic r, input logic c);
    task_ready = r;
    cpl_valid  = c;
    if (task_valid && r) hs_cnt++;
    @(negedge clk);
  endtask

  task automatic set_cfg(input int cn, input int oh, input int st, input int wh, input int eh);
    cfg_fmap_chn_n           = 16'(cn);
    cfg_ofmap_h              = 16'(oh);
    cfg_pool_vertical_stride = 3'(st);
    cfg_pool_window_h        = 8'(wh);
    cfg_ext_ifmap_h          = 16'(eh);
  endtask

  task automatic start_job(input int cn, input int oh, input int st, input int wh, input int eh);
    set_cfg(cn, oh, st, wh, eh);
    start = 1'b1; task_ready = 1'b0; cpl_valid = 1'b0;
    @(negedge clk);
    start = 1'b0;
  endtask

  // mode 0: random completions with cpl_pct; mode 1: each task completes 2 cycles after issue.
  task automatic run_job(input int cn, input int oh, input int st, input int wh, input int eh,
                         input int rdy_pct, input int mode, input int cpl_pct);
    tsk_t expq[$];
    tsk_t t;
    int   due[$];
    int   out_m;
    bit   active, exp_done, seen, was_drain, hs;
    logic r, c;
    got.delete();
    for (int ci = 0; ci <= cn; ci++) begin
      for (int ri = 0; ri <= oh; ri++) begin
        t.chn  = ci;
        t.row  = ri;
        t.rs   = ri * (st + 1);
        t.rn   = (t.rs + wh > eh) ? ((eh - t.rs) & 255) : wh;
        t.last = (ci == cn && ri == oh) ? 1 : 0;
        t.cyc  = 0;
        expq.push_back(t);
      end
    end
    start_job(cn, oh, st, wh, eh);
    out_m = 0; active = 1'b1; exp_done = 1'b0; seen = 1'b0;
    for (int cy = 0; cy < 4000 && !seen; cy++) begin
      chk("valid", task_valid, active && expq.size() > 0 && out_m < MAX);
      chk("busy", busy, active);
      chk("done", done, exp_done);
      chk("cpl_err_clean", cpl_err, 0);
      if (exp_done) begin
        seen = 1'b1;
      end else begin
        r = ($urandom_range(99) < rdy_pct);
        if (mode == 1) c = (due.size() > 0 && due[0] == cy);
        else           c = (out_m > 0 && $urandom_range(99) < cpl_pct);
        if (mode == 1 && c) void'(due.pop_front());
        hs = task_valid && r;
        was_drain = (expq.size() == 0);
        if (hs) begin
          t.chn = task_chn; t.row = task_ofmap_row; t.rs = task_ifmap_row_start;
          t.rn = task_ifmap_row_n; t.last = task_last; t.cyc = cy;
          got.push_back(t);
          if (was_drain) begin
            checks++; errors++;
            $display("FAIL extra_task act_row=%0d exp=none", t.row);
          end else begin
            chk("chn", t.chn, expq[0].chn);
            chk("row", t.row, expq[0].row);
            chk("row_start", t.rs, expq[0].rs);
            chk("row_n", t.rn, expq[0].rn);
            chk("last", t.last, expq[0].last);
            void'(expq.pop_front());
          end
          if (mode == 1) due.push_back(cy + 2);
        end
        out_m = out_m + int'(hs) - int'(c);
        if (was_drain && out_m == 0) begin
          exp_done = 1'b1;
          active   = 1'b0;
        end
        task_ready = r; cpl_valid = c;
        @(negedge clk);
      end
    end
    task_ready = 1'b0; cpl_valid = 1'b0;
    if (!seen) begin
      checks++; errors++;
      $display("FAIL job_timeout act=no_done exp=done");
    end
    @(negedge clk);
    chk("done_pulse", done, 0);
    chk("busy_after", busy, 0);
  endtask

  initial begin
    vec[0] = '{0, 3, 1, 2, 7, 0, 0, 0, 0, 2, 0};
    vec[1] = '{0, 3, 1, 2, 7, 1, 0, 1, 2, 2, 0};
    vec[2] = '{0, 3, 1, 2, 7, 2, 0, 2, 4, 2, 0};
    vec[3] = '{0, 3, 1, 2, 7, 3, 0, 3, 6, 1, 1};
    vec[4] = '{1, 1, 0, 1, 1, 0, 0, 0, 0, 1, 0};
    vec[5] = '{1, 1, 0, 1, 1, 1, 0, 1, 1, 0, 0};
    vec[6] = '{1, 1, 0, 1, 1, 2, 1, 0, 0, 1, 0};
    vec[7] = '{1, 1, 0, 1, 1, 3, 1, 1, 1, 0, 1};

    repeat (3) @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_valid", task_valid, 0);
    chk("rst_done", done, 0);
    chk("rst_err", cpl_err, 0);
    rst_n = 1'b1;
    @(negedge clk);

    // Table-driven jobs with ready held and fixed-latency completions.
    for (int i = 0; i < 8; i++) begin
      if (vec[i].idx == 0)
        run_job(vec[i].cn, vec[i].oh, vec[i].st, vec[i].wh, vec[i].eh, 100, 1, 0);
      if (got.size() > vec[i].idx) begin
        chk("tbl_chn", got[vec[i].idx].chn, vec[i].e_chn);
        chk("tbl_row", got[vec[i].idx].row, vec[i].e_row);
        chk("tbl_rs", got[vec[i].idx].rs, vec[i].e_rs);
        chk("tbl_rn", got[vec[i].idx].rn, vec[i].e_rn);
        chk("tbl_last", got[vec[i].idx].last, vec[i].e_last);
        chk("tbl_rate", got[vec[i].idx].cyc - got[0].cyc, vec[i].idx);
      end else begin
        checks++; errors++;
        $display("FAIL tbl_missing act=%0d exp_idx=%0d", got.size(), vec[i].idx);
      end
    end

    // Credit limit, re-open on completion, issue+completion in the same cycle.
    start_job(0, 7, 0, 0, 20);
    hs_cnt = 0;
    repeat (8) step(1, 0);
    chk("credit_hs", hs_cnt, 4);
    chk("credit_valid", task_valid, 0);
    step(0, 1);
    chk("reopen_valid", task_valid, 1);
    hs_cnt = 0;
    repeat (3) step(1, 0);
    chk("one_more_hs", hs_cnt, 1);
    chk("full_again", task_valid, 0);
    step(0, 1);
    step(1, 1);
    chk("same_cycle_valid", task_valid, 1);
    chk("same_cycle_row", task_ofmap_row, 6);
    step(1, 0);
    chk("refull_valid", task_valid, 0);
    rst_n = 1'b0; step(0, 0); rst_n = 1'b1;

    // Reset while draining with two tasks outstanding.
    start_job(0, 1, 0, 0, 5);
    step(1, 0);
    step(1, 0);
    chk("drain_busy", busy, 1);
    chk("drain_valid", task_valid, 0);
    rst_n = 1'b0;
    step(0, 0);
    chk("rd_busy", busy, 0);
    chk("rd_valid", task_valid, 0);
    chk("rd_last", task_last, 0);
    chk("rd_row", task_ofmap_row, 0);
    chk("rd_rs", task_ifmap_row_start, 0);
    chk("rd_rn", task_ifmap_row_n, 0);
    rst_n = 1'b1;
    for (int k = 0; k < 4; k++) begin
      step(0, 0);
      chk("rd_no_done", done, 0);
    end

    // Completion with nothing outstanding, single-task job.
    start_job(0, 0, 0, 3, 9);
    chk("single_last", task_last, 1);
    chk("single_rn", task_ifmap_row_n, 3);
    step(0, 1);
    chk("cpl_err_set", cpl_err, 1);
    chk("err_valid", task_valid, 1);
    step(1, 0);
    chk("single_drain", task_valid, 0);
    step(0, 1);
    chk("single_done", done, 1);
    chk("single_busy", busy, 0);
    chk("err_sticky", cpl_err, 1);
    step(0, 0);
    chk("single_done_pulse", done, 0);
    start_job(0, 0, 0, 3, 9);
    chk("err_cleared", cpl_err, 0);
    step(1, 0);
    step(0, 1);
    chk("rerun_done", done, 1);
    step(0, 0);

    // Randomized jobs against the model.
    for (int j = 0; j < 8; j++) begin
      int cn, oh, st, wh, eh;
      cn = $urandom_range(2);
      oh = $urandom_range(5);
      st = $urandom_range(7);
      wh = $urandom_range(15);
      eh = oh * (st + 1) + $urandom_range(20);
      run_job(cn, oh, st, wh, eh, 60, 0, 40);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
